mux_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select line of the team's 2:1 `mux` and shares that single output path between source A (mux input `a`) and source B (mux input `b`). Each requester raises a request, receives a registered grant, and holds the path for as long as it keeps requesting. An optional burst limit forces a handover when the other side is waiting. The block sits directly in front of `mux` and drives its `sel`.

---
 rtl/mux_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mux_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter that drives the select line of
// the shared 2:1 mux (sel=0 -> source A, sel=1 -> source B).
// Optional feature macro: MUX_ARB_FAIRNESS_EN enables the burst counter and
// preemption of an owner that has held the path for MAX_BURST cycles while
// the other side is waiting. Without it the owner keeps the path until it
// drops its request.
module mux_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   last_r;       // 0: A served last, 1: B served last
  logic   next_last_s;
  logic   sel_r;
  logic   next_sel_s;
  logic   preempt_a_s;  // A owns, has used its burst, and B is waiting
  logic   preempt_b_s;  // B owns, has used its burst, and A is waiting

  // An out-of-range configuration elaborates this empty marker block so the
  // parameters remain visible to elaboration in both build variants.
  if ((MAX_BURST < 2) || (MAX_BURST > 255) || ((2 ** CNT_W) <= MAX_BURST)) begin : g_illegal_cfg
  end

`ifdef MUX_ARB_FAIRNESS_EN
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;

  assign preempt_a_s = (cnt_r == MAX_CNT) && req_b;
  assign preempt_b_s = (cnt_r == MAX_CNT) && req_a;

  // Burst counter next value: load 1 on grant entry, count while staying, saturate.
  always_comb begin
    next_cnt_s = cnt_r;
    if (next_state_s == IDLE) begin
      next_cnt_s = cnt_r;
    end else if (next_state_s != state_r) begin
      next_cnt_s = CNT_W'(1);
    end else if (cnt_r == MAX_CNT) begin
      next_cnt_s = cnt_r;
    end else begin
      next_cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= next_cnt_s;
    end
  end
`else
  assign preempt_a_s = 1'b0;
  assign preempt_b_s = 1'b0;
`endif

  // State, priority pointer and mux select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      sel_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      last_r  <= next_last_s;
      sel_r   <= next_sel_s;
    end
  end

  // Next-state, priority pointer and select: grant transitions and handovers.
  always_comb begin
    next_state_s = state_r;
    next_last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (req_a && req_b) begin
          // Contention goes to the side not served last.
          next_state_s = last_r ? OWN_A : OWN_B;
          next_last_s  = ~last_r;
        end else if (req_a) begin
          next_state_s = OWN_A;
          next_last_s  = 1'b0;
        end else if (req_b) begin
          next_state_s = OWN_B;
          next_last_s  = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          if (req_b) begin
            next_state_s = OWN_B;
            next_last_s  = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end else if (preempt_a_s) begin
          // A preempted pointer marks A as the side served last.
          next_state_s = OWN_B;
          next_last_s  = 1'b0;
        end else begin
          next_state_s = OWN_A;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          if (req_a) begin
            next_state_s = OWN_A;
            next_last_s  = 1'b0;
          end else begin
            next_state_s = IDLE;
          end
        end else if (preempt_b_s) begin
          next_state_s = OWN_A;
          next_last_s  = 1'b1;
        end else begin
          next_state_s = OWN_B;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase

    // Select follows the new owner and holds through IDLE.
    case (next_state_s)
      OWN_A:   next_sel_s = 1'b0;
      OWN_B:   next_sel_s = 1'b1;
      default: next_sel_s = sel_r;
    endcase
  end

  // Outputs decoded purely from registers.
  always_comb begin
    gnt_a = (state_r == OWN_A);
    gnt_b = (state_r == OWN_B);
    busy  = (state_r == OWN_A) || (state_r == OWN_B);
    sel   = sel_r;
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed steps from the test plan plus
// randomized requests, compared against a behavioural ownership model.
// Works with or without MUX_ARB_FAIRNESS_EN defined.
module tb_mux_arbiter;

  localparam int MAX_BURST_TB = 8;

  logic clk;
  logic rst_n;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic sel;
  logic busy;

  int checks = 0;
  int errors = 0;

  // Reference model: owner 0 = nobody, 1 = A, 2 = B.
  int   m_owner;
  int   m_last;   // 0 = A served last, 1 = B served last
  int   m_burst;
  logic m_sel;

  mux_arbiter #(.MAX_BURST(MAX_BURST_TB), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (req_a),
    .req_b (req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 1;
    m_burst = 0;
    m_sel   = 1'b0;
  endtask

  // Apply the ownership rules for one rising edge with the sampled requests.
  task automatic model_edge(input logic a, input logic b);
    int  wants [3];
    int  nxt;
    bit  preempted;
    wants[0] = 0;
    wants[1] = int'(a);
    wants[2] = int'(b);
    nxt = m_owner;
    preempted = 1'b0;
    if (m_owner == 0) begin
      if (a && b) nxt = (m_last == 1) ? 1 : 2;
      else if (a) nxt = 1;
      else if (b) nxt = 2;
      else        nxt = 0;
    end else if (wants[m_owner] == 0) begin
      nxt = (wants[3 - m_owner] != 0) ? 3 - m_owner : 0;
    end else begin
`ifdef MUX_ARB_FAIRNESS_EN
      if (m_burst >= MAX_BURST_TB && wants[3 - m_owner] != 0) begin
        nxt = 3 - m_owner;
        preempted = 1'b1;
      end
`endif
    end
    if (nxt != 0 && nxt != m_owner) begin
      m_last  = preempted ? m_owner - 1 : nxt - 1;
      m_burst = 1;
    end else if (nxt != 0) begin
      m_burst = (m_burst < MAX_BURST_TB) ? m_burst + 1 : MAX_BURST_TB;
    end
    if (nxt == 1) m_sel = 1'b0;
    if (nxt == 2) m_sel = 1'b1;
    m_owner = nxt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt_a"}, gnt_a, (m_owner == 1));
    chk({tag, ".gnt_b"}, gnt_b, (m_owner == 2));
    chk({tag, ".sel"},   sel,   m_sel);
    chk({tag, ".busy"},  busy,  (m_owner != 0));
  endtask

  // Drive requests, let one edge pass, then compare 1 time unit later.
  task automatic step(input string tag, input logic a, input logic b);
    req_a = a;
    req_b = b;
    @(posedge clk);
    model_edge(a, b);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    req_a = 1'b0;
    req_b = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n_a;
    int n_b;
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    do_reset();
    check_all("reset_state");

    // Single requester: 5 cycles of req_a, grant for exactly 5 cycles.
    n_a = 0;
    repeat (5) begin
      step("single", 1'b1, 1'b0);
      n_a += int'(gnt_a);
      chk("single_sel", sel, 1'b0);
    end
    step("single_rel", 1'b0, 1'b0);
    chk("single_released", gnt_a, 1'b0);
    chk_int("single_len", n_a, 5);
    step("single_idle", 1'b0, 1'b0);

    // First contention out of reset goes to A, then direct handover to B.
    do_reset();
    step("contend", 1'b1, 1'b1);
    chk("contend_a_first", gnt_a, 1'b1);
    step("handover", 1'b0, 1'b1);
    chk("handover_b", gnt_b, 1'b1);
    chk("handover_sel", sel, 1'b1);

    // Round robin: after B, contention goes to A; after A, to B.
    step("rr_rel1", 1'b0, 1'b0);
    chk("rr_idle_sel_hold", sel, 1'b1);
    step("rr_both1", 1'b1, 1'b1);
    chk("rr_a_wins", gnt_a, 1'b1);
    step("rr_rel2", 1'b0, 1'b0);
    step("rr_both2", 1'b1, 1'b1);
    chk("rr_b_wins", gnt_b, 1'b1);
    step("rr_rel3", 1'b0, 1'b0);

    // Both requesters held continuously.
    do_reset();
    n_a = 0;
    n_b = 0;
    repeat (40) begin
      step("hold_both", 1'b1, 1'b1);
      n_a += int'(gnt_a);
      n_b += int'(gnt_b);
    end
`ifdef MUX_ARB_FAIRNESS_EN
    chk_int("hold_a_cycles", n_a, 24);
    chk_int("hold_b_cycles", n_b, 16);
`else
    chk_int("hold_a_cycles", n_a, 40);
    chk_int("hold_b_cycles", n_b, 0);
`endif
    step("hold_rel", 1'b0, 1'b0);

    // Reset asserted mid-grant clears outputs without a clock edge.
    step("mid_b1", 1'b0, 1'b1);
    step("mid_b2", 1'b0, 1'b1);
    chk("mid_in_own_b", gnt_b, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_gnt_b", gnt_b, 1'b0);
    chk("midrst_sel", sel, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    check_all("midrst_all");
    req_a = 1'b0;
    req_b = 1'b0;
    @(posedge clk);
    #1;
    check_all("midrst_held");
    rst_n = 1'b1;
    step("post_rst", 1'b0, 1'b1);
    chk("post_rst_first_grant", gnt_b, 1'b1);

    // Randomized requests, biased towards held requests to exercise long bursts.
    repeat (400) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    repeat (200) begin
      step("rand_sparse", ($urandom_range(0, 1) != 0), ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
